// File: rtl/e_sdio_pkg.sv
// ============================================================================
//  Module      : e_sdio_pkg
//  Description : Shared state encoding and constants for the SD data TX path.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package e_sdio_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_WAIT_RDY  = 4'd1;
    localparam state_t S_START     = 4'd2;
    localparam state_t S_DATA      = 4'd3;
    localparam state_t S_CRC       = 4'd4;
    localparam state_t S_END       = 4'd5;
    localparam state_t S_TURN      = 4'd6;
    localparam state_t S_STAT_WAIT = 4'd7;
    localparam state_t S_STAT      = 4'd8;
    localparam state_t S_BUSY      = 4'd9;
    localparam state_t S_FIN       = 4'd10;

    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [2:0]  TOK_ACCEPT  = 3'b010;
    localparam logic [2:0]  TOK_CRC_ERR = 3'b101;

    localparam int NUM_LANES  = 4;
    localparam int LANES_1BIT = 1;
    localparam int LANES_4BIT = 4;

endpackage

`default_nettype wire

// File: rtl/e_crc16_serial.sv
// ============================================================================
//  Module      : e_crc16_serial
//  Description : Bit-serial CRC16-CCITT with clear, update and shift-out modes.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module e_crc16_serial
    import e_sdio_pkg::*;
(
    input  logic clk,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    input  logic din,
    input  logic shift,
    output logic msb
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb = din ^ r_crc[15];
    assign msb  = r_crc[15];

    // Shift-out mode pushes zeros in so the word leaves MSB first.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_crc <= '0;
        end else if (clr) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end else if (shift) begin
            r_crc <= {r_crc[14:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/e_dat_tx.sv
// ============================================================================
//  Module      : e_dat_tx
//  Description : SD DAT-line block transmitter with CRC status and busy wait.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module e_dat_tx
    import e_sdio_pkg::*;
#(
    parameter int STAT_TO = 16,
    parameter int BUSY_TO = 65535,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start,
    input  logic        abort,
    input  logic        bus_4bit,
    input  logic [11:0] block_size,
    input  logic        buffer_read_rdy,
    input  logic [7:0]  pop_data,
    output logic        pop,
    output logic [3:0]  dat_out,
    output logic        dat_oe,
    input  logic        dat_in0,
    output logic        tx_busy,
    output logic        done,
    output logic        crc_err,
    output logic        timeout
);

    localparam logic [CNT_W-1:0] c_stat_lim = CNT_W'(STAT_TO - 1);
    localparam logic [CNT_W-1:0] c_busy_lim = CNT_W'(BUSY_TO - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_mode4;
    logic [11:0]      r_size;
    logic [11:0]      r_byte_cnt;
    logic [7:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_tok;
    logic             r_crc_err;
    logic             r_timeout;

    logic             w_accept;
    logic             w_last_bit;
    logic             w_more;
    logic             w_stat_to;
    logic             w_busy_to;
    logic [3:0]       w_lanes;
    logic [3:0]       w_crc_msb;
    logic [3:0]       w_crc_en;
    logic             w_crc_clr;
    logic             w_crc_shift;

    assign w_accept    = (r_state == S_IDLE) && start && (block_size != 12'd0) && !abort;
    assign w_last_bit  = (r_bit_cnt == (r_mode4 ? 4'd1 : 4'd7));
    assign w_more      = (r_byte_cnt != 12'd0);
    assign w_stat_to   = (r_cnt == c_stat_lim);
    assign w_busy_to   = (r_cnt == c_busy_lim);
    assign w_lanes     = r_mode4 ? r_shift[7:4] : {3'b111, r_shift[7]};
    assign w_crc_clr   = (r_state == S_START);
    assign w_crc_shift = (r_state == S_CRC);

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign w_crc_en[i] = (r_state == S_DATA) && ((i == 0) ? 1'b1 : r_mode4);

            e_crc16_serial u_crc (
                .clk   (clk),
                .rst_i (rst_i),
                .clr   (w_crc_clr),
                .en    (w_crc_en[i]),
                .din   (w_lanes[i]),
                .shift (w_crc_shift),
                .msb   (w_crc_msb[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next = S_WAIT_RDY;
            S_WAIT_RDY:  if (buffer_read_rdy) w_next = S_START;
            S_START:     w_next = S_DATA;
            S_DATA:      if (w_last_bit && !w_more) w_next = S_CRC;
            S_CRC:       if (r_bit_cnt == 4'd15) w_next = S_END;
            S_END:       w_next = S_TURN;
            S_TURN:      if (r_bit_cnt == 4'd1) w_next = S_STAT_WAIT;
            S_STAT_WAIT: begin
                if (!dat_in0)       w_next = S_STAT;
                else if (w_stat_to) w_next = S_FIN;
            end
            S_STAT:      if (r_bit_cnt == 4'd3) w_next = S_BUSY;
            S_BUSY: begin
                if (dat_in0)        w_next = S_FIN;
                else if (w_busy_to) w_next = S_FIN;
            end
            S_FIN:       w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_mode4    <= 1'b0;
            r_size     <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_cnt      <= '0;
            r_tok      <= '0;
            r_crc_err  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode4   <= bus_4bit;
                r_size    <= block_size;
                r_crc_err <= 1'b0;
                r_timeout <= 1'b0;
            end
            // Bit counter restarts on every state change and at each byte boundary.
            if ((w_next != r_state) || ((r_state == S_DATA) && w_last_bit)) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            case (r_state)
                S_START: begin
                    r_shift    <= pop_data;
                    r_byte_cnt <= r_size - 12'd1;
                end
                S_DATA: begin
                    if (w_last_bit && w_more) begin
                        r_shift    <= pop_data;
                        r_byte_cnt <= r_byte_cnt - 12'd1;
                    end else begin
                        r_shift <= r_mode4 ? {r_shift[3:0], 4'h0} : {r_shift[6:0], 1'b0};
                    end
                end
                S_TURN: r_cnt <= '0;
                S_STAT_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dat_in0 && w_stat_to && !abort) r_timeout <= 1'b1;
                end
                S_STAT: begin
                    r_cnt <= '0;
                    if (r_bit_cnt < 4'd3) begin
                        r_tok <= {r_tok[1:0], dat_in0};
                    end else if (!abort) begin
                        r_crc_err <= (r_tok != TOK_ACCEPT);
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!dat_in0 && w_busy_to && !abort) r_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dat_out = 4'hF;
        dat_oe  = 1'b0;
        pop     = 1'b0;
        done    = (r_state == S_FIN);
        tx_busy = (r_state != S_IDLE) && (r_state != S_FIN);
        case (r_state)
            S_START: begin
                dat_oe  = 1'b1;
                dat_out = r_mode4 ? 4'h0 : 4'hE;
                pop     = 1'b1;
            end
            S_DATA: begin
                dat_oe  = 1'b1;
                dat_out = w_lanes;
                pop     = w_last_bit && w_more;
            end
            S_CRC: begin
                dat_oe  = 1'b1;
                dat_out = r_mode4 ? w_crc_msb : {3'b111, w_crc_msb[0]};
            end
            S_END: begin
                dat_oe  = 1'b1;
            end
            default: ;
        endcase
    end

    assign crc_err = r_crc_err;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: doc/e_dat_tx.md
Name: e_dat_tx

Overview:
- SD data-line transmitter on the card-clock side of the write path. It sits directly downstream of the TX byte FIFO.
- Pops bytes from the FIFO and drives one block onto DAT[0] (1-bit mode) or DAT[3:0] (4-bit mode): start bit, payload, per-lane CRC16, end bit.
- Then samples the card's CRC status token and waits out DAT0 busy, reporting done/crc_err/timeout to the command/data controller.

Parameters:
STAT_TO, 16, max clk cycles from end bit to CRC-status start bit before timeout
BUSY_TO, 65535, max clk cycles of DAT0 low busy before timeout
CNT_W, 16, width of shared timeout counter (must hold BUSY_TO)

Ports:
clk  in  1  card clock (sd_clk domain); all logic posedge
rst_i  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: send one block
abort  in  1  synchronous: release lines, return IDLE, no done
bus_4bit  in  1  1 = 4-bit mode, 0 = 1-bit; sampled on start
block_size  in  12  bytes per block, sampled on start
buffer_read_rdy  in  1  FIFO holds a full block
pop_data  in  8  show-ahead FIFO head byte
pop  out  1  advance FIFO head at next clk
dat_out  out  4  DAT line drive values
dat_oe  out  1  drive enable for active lanes
dat_in0  in  1  DAT0 sampled from card
tx_busy  out  1  high from start accept until done/abort
done  out  1  one-cycle pulse at block completion
crc_err  out  1  valid with done: status token not 3'b010
timeout  out  1  valid with done: status or busy timeout

Behaviour:
- Reset values: dat_out=4'hF, dat_oe=0, pop=0, tx_busy=0, done=0, crc_err=0, timeout=0; state IDLE.
- States: IDLE, WAIT_RDY, START, DATA, CRC, END, TURN, STAT_WAIT, STAT, BUSY, FIN.
- IDLE -> WAIT_RDY on start with block_size!=0. Latch bus_4bit and block_size; tx_busy=1.
- start with block_size==0 is ignored. start while tx_busy is ignored.
- WAIT_RDY -> START when buffer_read_rdy=1.
- START (1 cycle):
  - dat_oe=1; active lanes driven 0, unused lanes 1.
  - Shift reg <= pop_data; pop=1; byte counter <= block_size-1; CRCs cleared to 0.
- DATA, 1-bit mode: 8 cycles/byte, MSB first on dat_out[0].
- DATA, 4-bit mode: 2 cycles/byte; high nibble then low nibble, bit3 on dat_out[3].
- On the last cycle of a byte with byte counter!=0: shift reg <= pop_data, pop=1, counter decrements.
- Total pops per block = block_size exactly. pop never asserted on the final byte or outside START/DATA.
- CRC: CRC16-CCITT (x^16+x^12+x^5+1), init 0, one per lane, updated on each bit driven in DATA.
- CRC state: 16 cycles, each lane shifts out its CRC MSB first.
- END: 1 cycle, all lanes 1.
- TURN: 2 cycles, dat_oe=0. Timeout counter cleared.
- STAT_WAIT: wait for dat_in0=0 (status start bit). If the counter reaches STAT_TO: timeout=1, go to FIN.
- STAT: capture 3 bits of dat_in0. crc_err=1 unless the token equals 3'b010. Then 1 cycle for the token end bit, go to BUSY.
- BUSY: wait for dat_in0=1. If the counter reaches BUSY_TO: timeout=1, go to FIN.
- FIN: done=1 for one cycle; tx_busy=0; crc_err/timeout held until the next start; go to IDLE.
- abort in any state: next cycle dat_oe=0, dat_out=4'hF, pop=0, IDLE, no done.
- rst_i mid-block: immediate return to reset values. The FIFO's own reset discards the residual bytes.
- block_size=1 in 1-bit mode: exactly 1 pop (in START), 8 data cycles.

Decomposition:
- Package e_sdio_pkg holds:
  - the state encoding
  - CRC16_POLY=16'h1021
  - TOK_ACCEPT=3'b010 and TOK_CRC_ERR=3'b101
  - lane-count constants
- Sub-module e_crc16_serial: 1-bit serial CRC16 with clear, enable, data bit, shift-out mode.
  - Four instances, one per lane. Lanes 1-3 enabled only in 4-bit mode.

Test Plan:
- 1-bit, block_size=512, all bytes 8'hFF, card returns 3'b010, busy 20 cycles -> CRC out on DAT0 = 16'h7FA1; 512 pops; done with crc_err=0, timeout=0.
- 4-bit, block_size=4, bytes 8'hA5,8'h3C,8'h00,8'hFF -> lanes show nibbles A,5,3,C,0,0,F,F; 4 pops; 4 CRC words match reference model.
- Card returns 3'b101 -> done with crc_err=1. Repeat with 3'b111 -> crc_err=1.
- No status start bit -> after STAT_TO cycles: done with timeout=1. DAT0 held low -> after BUSY_TO cycles: done with timeout=1.
- abort during DATA byte 3 -> dat_oe=0 next cycle, pop stops, no done pulse; a subsequent start runs cleanly.
- rst_i asserted mid-CRC -> all outputs at reset values immediately. A start with block_size=0 -> tx_busy stays 0.
